// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel synchronise/debounce/edge/auto-repeat input conditioner
//
// Purpose: each channel conditions one raw labkit button or switch into a
// clean level plus one-cycle press/release pulses and an optional
// hold-to-repeat pulse train. Channels are fully independent.
//
// Ports:
//   clock_27mhz       in   1      system clock
//   reset             in   1      synchronous, active-high reset
//   noisy_i           in   WIDTH  raw asynchronous inputs
//   clean_o           out  WIDTH  debounced level (after INVERT)
//   pressed_o         out  WIDTH  one-cycle pulse on clean 0->1
//   released_o        out  WIDTH  one-cycle pulse on clean 1->0
//   repeat_pulse_o    out  WIDTH  press pulse plus auto-repeat pulses
module debounce_bank #(
  parameter int               WIDTH        = 8,
  parameter int               DELAY        = 270000,
  parameter logic [WIDTH-1:0] INVERT       = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] REPEAT_EN    = {WIDTH{1'b0}},
  parameter int               REPEAT_START = 8100000,
  parameter int               REPEAT_RATE  = 2700000
) (
  input  logic             clock_27mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] noisy_i,
  output logic [WIDTH-1:0] clean_o,
  output logic [WIDTH-1:0] pressed_o,
  output logic [WIDTH-1:0] released_o,
  output logic [WIDTH-1:0] repeat_pulse_o
);

  localparam int CW   = $clog2(DELAY + 1);
  localparam int RMAX = (REPEAT_START > REPEAT_RATE) ? REPEAT_START : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DELAY - 1);
  localparam logic [RW-1:0] START_LAST = RW'(REPEAT_START - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic          s1_q, s2_q, cand_q, clean_q;
    logic          pressed_q, released_q, rpulse_q, rphase_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] rcnt_q;

    logic          s1_d, s2_d, cand_d, clean_d;
    logic          pressed_d, released_d, rpulse_d, rphase_d;
    logic [CW-1:0] cnt_d;
    logic [RW-1:0] rcnt_d;

    always_comb begin
      s1_d       = noisy_i[i] ^ INVERT[i];
      s2_d       = s1_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      clean_d    = clean_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      rpulse_d   = 1'b0;
      rcnt_d     = rcnt_q;
      rphase_d   = rphase_q;

      // Any change of the synchronised level restarts the stability window;
      // once full, the counter parks at its last value until the next change.
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        cnt_d  = '0;
      end else if (cnt_q == CNT_LAST) begin
        clean_d = cand_q;
        if (cand_q != clean_q) begin
          pressed_d  = cand_q;
          released_d = ~cand_q;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      if (REPEAT_EN[i]) begin
        if (pressed_d) begin
          rpulse_d = 1'b1;
          rcnt_d   = '0;
          rphase_d = 1'b0;
        end else if (clean_q) begin
          // Phase 0 waits out the initial hold delay, phase 1 is periodic.
          if (rcnt_q == (rphase_q ? RATE_LAST : START_LAST)) begin
            rpulse_d = 1'b1;
            rcnt_d   = '0;
            rphase_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end else begin
          rcnt_d   = '0;
          rphase_d = 1'b0;
        end
      end else begin
        rpulse_d = pressed_d;
        rcnt_d   = '0;
        rphase_d = 1'b0;
      end
    end

    always_ff @(posedge clock_27mhz) begin
      if (reset) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        cand_q     <= 1'b0;
        cnt_q      <= '0;
        clean_q    <= 1'b0;
        pressed_q  <= 1'b0;
        released_q <= 1'b0;
        rpulse_q   <= 1'b0;
        rcnt_q     <= '0;
        rphase_q   <= 1'b0;
      end else begin
        s1_q       <= s1_d;
        s2_q       <= s2_d;
        cand_q     <= cand_d;
        cnt_q      <= cnt_d;
        clean_q    <= clean_d;
        pressed_q  <= pressed_d;
        released_q <= released_d;
        rpulse_q   <= rpulse_d;
        rcnt_q     <= rcnt_d;
        rphase_q   <= rphase_d;
      end
    end

    assign clean_o[i]        = clean_q;
    assign pressed_o[i]      = pressed_q;
    assign released_o[i]     = released_q;
    assign repeat_pulse_o[i] = rpulse_q;
  end

endmodule
